// File: rtl/cc_delay_sequencer_if.sv
// Handshake bundle for cc_delay_sequencer: upstream word/delay/valid, downstream valid/ready, busy status.
// slave is the sequencer's view; master is the view of whatever drives and observes it.
interface cc_delay_sequencer_if #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int DELAYWIDTH    = 4
);
  logic [DATAWIDTH_BUS-1:0] CC_DELAY_SEQ_Data_inBus;
  logic [DELAYWIDTH-1:0]    CC_DELAY_SEQ_Cycles_inBus;
  logic                     CC_DELAY_SEQ_Valid_In;
  logic                     CC_DELAY_SEQ_Ready_Out;
  logic [DATAWIDTH_BUS-1:0] CC_DELAY_SEQ_Data_outBus;
  logic                     CC_DELAY_SEQ_Valid_Out;
  logic                     CC_DELAY_SEQ_Ready_In;
  logic                     CC_DELAY_SEQ_Busy_Out;

  modport slave (
    input  CC_DELAY_SEQ_Data_inBus,
    input  CC_DELAY_SEQ_Cycles_inBus,
    input  CC_DELAY_SEQ_Valid_In,
    output CC_DELAY_SEQ_Ready_Out,
    output CC_DELAY_SEQ_Data_outBus,
    output CC_DELAY_SEQ_Valid_Out,
    input  CC_DELAY_SEQ_Ready_In,
    output CC_DELAY_SEQ_Busy_Out
  );

  modport master (
    output CC_DELAY_SEQ_Data_inBus,
    output CC_DELAY_SEQ_Cycles_inBus,
    output CC_DELAY_SEQ_Valid_In,
    input  CC_DELAY_SEQ_Ready_Out,
    input  CC_DELAY_SEQ_Data_outBus,
    input  CC_DELAY_SEQ_Valid_Out,
    output CC_DELAY_SEQ_Ready_In,
    input  CC_DELAY_SEQ_Busy_Out
  );
endinterface

// File: rtl/cc_delay_sequencer.sv
// Single-slot programmable delay: holds one accepted word for N extra cycles, then offers it downstream.
// Define CC_DELAY_SEQ_CNT_EN to add a saturating 8-bit handoff counter output.
module cc_delay_sequencer #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int DELAYWIDTH    = 4
) (
  input  logic                CC_DELAY_SEQ_CLOCK_50,
  input  logic                CC_DELAY_SEQ_RESET_InHigh,
  input  logic                CC_DELAY_SEQ_Flush_In,
  cc_delay_sequencer_if.slave bus
`ifdef CC_DELAY_SEQ_CNT_EN
  ,
  output logic [7:0]          CC_DELAY_SEQ_Count_outBus
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                   state;
  logic [DELAYWIDTH-1:0]    counter;
  logic [DATAWIDTH_BUS-1:0] data_q;
  logic                     valid_q;
  logic                     busy_q;
  logic                     ready;
  logic                     accept;
  logic                     handoff;

  // In OUT a new word may only enter in the same cycle the held one leaves.
  assign ready   = !CC_DELAY_SEQ_RESET_InHigh && !CC_DELAY_SEQ_Flush_In &&
                   ((state == IDLE) || ((state == OUT) && bus.CC_DELAY_SEQ_Ready_In));
  assign accept  = bus.CC_DELAY_SEQ_Valid_In && ready;
  assign handoff = valid_q && bus.CC_DELAY_SEQ_Ready_In;

  assign bus.CC_DELAY_SEQ_Ready_Out   = ready;
  assign bus.CC_DELAY_SEQ_Data_outBus = data_q;
  assign bus.CC_DELAY_SEQ_Valid_Out   = valid_q;
  assign bus.CC_DELAY_SEQ_Busy_Out    = busy_q;

  always_ff @(posedge CC_DELAY_SEQ_CLOCK_50) begin
    if (CC_DELAY_SEQ_RESET_InHigh) begin
      state   <= IDLE;
      counter <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (CC_DELAY_SEQ_Flush_In) begin
      state   <= IDLE;
      counter <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q  <= bus.CC_DELAY_SEQ_Data_inBus;
            counter <= bus.CC_DELAY_SEQ_Cycles_inBus;
            state   <= WAIT;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          // Counter only moves while nonzero, so it can never wrap.
          if (counter == '0) begin
            state   <= OUT;
            valid_q <= 1'b1;
          end else begin
            counter <= counter - DELAYWIDTH'(1);
          end
        end
        OUT: begin
          if (handoff) begin
            valid_q <= 1'b0;
            if (accept) begin
              data_q  <= bus.CC_DELAY_SEQ_Data_inBus;
              counter <= bus.CC_DELAY_SEQ_Cycles_inBus;
              state   <= WAIT;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CC_DELAY_SEQ_CNT_EN
  logic [7:0] handoff_count;

  // Survives flush on purpose; only reset clears the statistic.
  always_ff @(posedge CC_DELAY_SEQ_CLOCK_50) begin
    if (CC_DELAY_SEQ_RESET_InHigh) begin
      handoff_count <= 8'd0;
    end else if (handoff && (handoff_count != 8'hFF)) begin
      handoff_count <= handoff_count + 8'd1;
    end
  end

  assign CC_DELAY_SEQ_Count_outBus = handoff_count;
`endif

endmodule

// File: tb/tb_cc_delay_sequencer.sv
// Directed vector bench for cc_delay_sequencer: per-cycle table plus hand sequences for max delay
// and (with CC_DELAY_SEQ_CNT_EN) the saturating handoff counter.
module tb_cc_delay_sequencer;

  logic clk;
  logic rst;
  logic flush;
`ifdef CC_DELAY_SEQ_CNT_EN
  logic [7:0] count_out;
`endif

  int errors = 0;
  int checks = 0;

  cc_delay_sequencer_if #(.DATAWIDTH_BUS(8), .DELAYWIDTH(4)) bus_if ();

  cc_delay_sequencer #(.DATAWIDTH_BUS(8), .DELAYWIDTH(4)) dut (
    .CC_DELAY_SEQ_CLOCK_50     (clk),
    .CC_DELAY_SEQ_RESET_InHigh (rst),
    .CC_DELAY_SEQ_Flush_In     (flush),
    .bus                       (bus_if)
`ifdef CC_DELAY_SEQ_CNT_EN
    ,
    .CC_DELAY_SEQ_Count_outBus (count_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied before an edge; exp_ready is checked before it, the rest after it.
  typedef struct {
    logic       rst;
    logic       flush;
    logic       valid_in;
    logic [7:0] data_in;
    logic [3:0] cycles_in;
    logic       ready_in;
    logic       exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic f, input logic v, input logic [7:0] d,
                         input logic [3:0] c, input logic ri, input logic er, input logic ev,
                         input logic [7:0] ed, input logic eb);
    vec_t t;
    t.rst = r; t.flush = f; t.valid_in = v; t.data_in = d; t.cycles_in = c; t.ready_in = ri;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_busy = eb;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic [7:0] d,
                               input logic [3:0] c, input logic ri);
    rst                              = r;
    flush                            = f;
    bus_if.CC_DELAY_SEQ_Valid_In     = v;
    bus_if.CC_DELAY_SEQ_Data_inBus   = d;
    bus_if.CC_DELAY_SEQ_Cycles_inBus = c;
    bus_if.CC_DELAY_SEQ_Ready_In     = ri;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    int wait_cycles;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);

    //       rst flu vin data   cyc  rin  erdy eval edata  ebusy
    // Reset held two cycles with Valid_In high, then release.
    add_vec(1, 0, 1, 8'h55, 4'h0, 0,   0, 0, 8'h00, 0);
    add_vec(1, 0, 1, 8'h55, 4'h0, 0,   0, 0, 8'h00, 0);
    add_vec(0, 0, 0, 8'h00, 4'h0, 0,   1, 0, 8'h00, 0);
    // 0xA5 with N=3; Cycles_inBus changes after accept and must be ignored.
    add_vec(0, 0, 1, 8'hA5, 4'h3, 1,   1, 0, 8'hA5, 1);
    add_vec(0, 0, 0, 8'h00, 4'h9, 1,   0, 0, 8'hA5, 1);
    add_vec(0, 0, 0, 8'h00, 4'h9, 1,   0, 0, 8'hA5, 1);
    add_vec(0, 0, 0, 8'h00, 4'h9, 1,   0, 0, 8'hA5, 1);
    add_vec(0, 0, 0, 8'h00, 4'h9, 1,   0, 1, 8'hA5, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 1,   1, 0, 8'hA5, 0);
    // 0x3C with N=0 under backpressure; Valid_In in OUT without Ready_In is ignored.
    add_vec(0, 0, 1, 8'h3C, 4'h0, 0,   1, 0, 8'h3C, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 0,   0, 1, 8'h3C, 1);
    for (int i = 0; i < 4; i++)
      add_vec(0, 0, 1, 8'h99, 4'h2, 0, 0, 1, 8'h3C, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 1,   1, 0, 8'h3C, 0);
    // Back-to-back: handoff of 0x22 and accept of 0x11 (N=2) on the same edge.
    add_vec(0, 0, 1, 8'h22, 4'h0, 0,   1, 0, 8'h22, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 0,   0, 1, 8'h22, 1);
    add_vec(0, 0, 1, 8'h11, 4'h2, 1,   1, 0, 8'h11, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 1,   0, 0, 8'h11, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 1,   0, 0, 8'h11, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 1,   0, 1, 8'h11, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 1,   1, 0, 8'h11, 0);
    // Flush 0x77 (N=10) mid-wait; 0x88 offered during flush is refused, then accepted.
    add_vec(0, 0, 1, 8'h77, 4'hA, 1,   1, 0, 8'h77, 1);
    for (int i = 0; i < 3; i++)
      add_vec(0, 0, 0, 8'h00, 4'h0, 1, 0, 0, 8'h77, 1);
    add_vec(0, 1, 1, 8'h88, 4'h1, 1,   0, 0, 8'h77, 0);
    add_vec(0, 0, 1, 8'h88, 4'h1, 1,   1, 0, 8'h88, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 1,   0, 0, 8'h88, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 1,   0, 1, 8'h88, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 1,   1, 0, 8'h88, 0);
    // Flush while presenting keeps the data word but drops Valid_Out.
    add_vec(0, 0, 1, 8'h5A, 4'h0, 0,   1, 0, 8'h5A, 1);
    add_vec(0, 0, 0, 8'h00, 4'h0, 0,   0, 1, 8'h5A, 1);
    add_vec(0, 1, 0, 8'h00, 4'h0, 0,   0, 0, 8'h5A, 0);
    // Reset mid-stream clears the data word.
    add_vec(0, 0, 1, 8'h6B, 4'h4, 0,   1, 0, 8'h6B, 1);
    add_vec(1, 0, 1, 8'h6B, 4'h4, 0,   0, 0, 8'h00, 0);
    add_vec(0, 0, 0, 8'h00, 4'h0, 0,   1, 0, 8'h00, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].valid_in, vecs[i].data_in,
                    vecs[i].cycles_in, vecs[i].ready_in);
      #1;
      checkOutput($sformatf("v%0d ready_out", i), 32'(bus_if.CC_DELAY_SEQ_Ready_Out), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d valid_out", i), 32'(bus_if.CC_DELAY_SEQ_Valid_Out), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d data_out", i), 32'(bus_if.CC_DELAY_SEQ_Data_outBus), 32'(vecs[i].exp_data));
      checkOutput($sformatf("v%0d busy_out", i), 32'(bus_if.CC_DELAY_SEQ_Busy_Out), 32'(vecs[i].exp_busy));
    end

    // Maximum delay N=15: Valid_Out must rise exactly 16 edges after the accept edge.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hC3, 4'hF, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    wait_cycles = 0;
    while (!bus_if.CC_DELAY_SEQ_Valid_Out && wait_cycles < 40) begin
      @(posedge clk);
      #1;
      wait_cycles++;
    end
    checkOutput("max_delay latency", 32'(wait_cycles), 32'd16);
    checkOutput("max_delay data", 32'(bus_if.CC_DELAY_SEQ_Data_outBus), 32'hC3);
    @(negedge clk);
    bus_if.CC_DELAY_SEQ_Ready_In = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("max_delay valid after handoff", 32'(bus_if.CC_DELAY_SEQ_Valid_Out), 32'd0);
    checkOutput("max_delay busy after handoff", 32'(bus_if.CC_DELAY_SEQ_Busy_Out), 32'd0);

`ifdef CC_DELAY_SEQ_CNT_EN
    // Counter: reset, then stream N=0 words with Ready_In high (one handoff per two cycles).
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h12, 4'h0, 1'b1);
    #1;
    checkOutput("count after reset", 32'(count_out), 32'd0);
    repeat (520) @(posedge clk);
    #1;
    checkOutput("count saturated", 32'(count_out), 32'd255);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("count after flush", 32'(count_out), 32'd255);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("count after second reset", 32'(count_out), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
